// File: rtl/noc_params.sv
// Shared NoC sizing and flit format used by mesh routers and their local-port endpoints.
package noc_params;

  localparam int VC_NUM            = 4;
  localparam int VC_SIZE           = $clog2(VC_NUM);
  localparam int DEST_ADDR_SIZE_X  = 2;
  localparam int DEST_ADDR_SIZE_Y  = 2;
  localparam int FLIT_DATA_SIZE    = 16;
  localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  // Layout of the data field in a HEAD/HEADTAIL flit; routers read the destination from it.
  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [VC_SIZE-1:0]        vc_id;
    logic [FLIT_DATA_SIZE-1:0] data;
  } flit_t;

endpackage

// File: rtl/node_injector_pkg.sv
// Injector-local types: FSM state encoding and the flit labelling rule.
package node_injector_pkg;
  import noc_params::*;

  typedef enum logic [1:0] {IDLE, VC_SEL, SEND} injector_state_t;

  // A single-flit packet is HEADTAIL; otherwise first is HEAD, last is TAIL, the rest BODY.
  function automatic flit_label_t pick_label(input logic single, input logic first,
                                             input logic last);
    if (single)     return HEADTAIL;
    else if (first) return HEAD;
    else if (last)  return TAIL;
    else            return BODY;
  endfunction

endpackage

// File: rtl/node_injector_if.sv
// Descriptor, payload and router-local-port signals of one node injector.
interface node_injector_if
  import noc_params::*;
#(
  parameter int LEN_W = 4,
  parameter int CNT_W = 32
);

  logic                        pkt_valid_i;
  logic                        pkt_ready_o;
  logic [DEST_ADDR_SIZE_X-1:0] pkt_dest_x_i;
  logic [DEST_ADDR_SIZE_Y-1:0] pkt_dest_y_i;
  logic [LEN_W-1:0]            pkt_len_i;
  logic                        pld_valid_i;
  logic                        pld_ready_o;
  logic [FLIT_DATA_SIZE-1:0]   pld_data_i;
  flit_t                       data_o;
  logic                        is_valid_o;
  logic [VC_NUM-1:0]           is_on_off_i;
  logic [VC_NUM-1:0]           is_allocatable_i;
  logic                        busy_o;
  logic                        pkt_sent_o;
  logic                        error_o;
  logic [CNT_W-1:0]            flit_cnt_o;

  // master: traffic source plus router feedback; slave: the injector itself.
  modport master (
    output pkt_valid_i, pkt_dest_x_i, pkt_dest_y_i, pkt_len_i,
           pld_valid_i, pld_data_i, is_on_off_i, is_allocatable_i,
    input  pkt_ready_o, pld_ready_o, data_o, is_valid_o,
           busy_o, pkt_sent_o, error_o, flit_cnt_o
  );

  modport slave (
    input  pkt_valid_i, pkt_dest_x_i, pkt_dest_y_i, pkt_len_i,
           pld_valid_i, pld_data_i, is_on_off_i, is_allocatable_i,
    output pkt_ready_o, pld_ready_o, data_o, is_valid_o,
           busy_o, pkt_sent_o, error_o, flit_cnt_o
  );

endinterface

// File: rtl/node_injector_vc_select.sv
// Rotating-priority search: first set request bit at or above ptr, wrapping around.
module injector_vc_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         found
);

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        grant = W'((int'(ptr) + i) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/node_injector.sv
// Local-port traffic source: turns (dest, len) descriptors plus a payload stream into
// a HEAD/BODY/TAIL flit sequence on one round-robin-chosen virtual channel.
module node_injector
  import noc_params::*;
  import node_injector_pkg::*;
#(
  parameter int X_CURRENT     = 0,
  parameter int Y_CURRENT     = 0,
  parameter int MAX_PKT_FLITS = 8,
  parameter int LEN_W         = $clog2(MAX_PKT_FLITS + 1),
  parameter int CNT_W         = 32
) (
  input logic            clk,
  input logic            rst,
  node_injector_if.slave bus
);

  // Node coordinates are debug labels only; this block exists solely for illegal placements.
  if (X_CURRENT < 0 || Y_CURRENT < 0 || MAX_PKT_FLITS < 1) begin : g_bad_config
  end

  injector_state_t             state_q, state_d;
  logic [VC_SIZE-1:0]          rr_ptr_q, vc_q, grant;
  logic                        found;
  logic [DEST_ADDR_SIZE_X-1:0] dest_x_q;
  logic [DEST_ADDR_SIZE_Y-1:0] dest_y_q;
  logic [LEN_W-1:0]            len_q, remaining_q;
  flit_t                       data_q, flit_d;
  head_data_t                  head_d;
  logic                        valid_q, sent_q, error_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        pkt_hs, pld_hs, len_ok, first_word, last_word;

  assign bus.pkt_ready_o = (state_q == IDLE);
  assign bus.pld_ready_o = (state_q == SEND) && bus.is_on_off_i[vc_q];
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.data_o      = data_q;
  assign bus.is_valid_o  = valid_q;
  assign bus.pkt_sent_o  = sent_q;
  assign bus.error_o     = error_q;
  assign bus.flit_cnt_o  = cnt_q;

  assign pkt_hs     = bus.pkt_valid_i && bus.pkt_ready_o;
  assign pld_hs     = bus.pld_valid_i && bus.pld_ready_o;
  assign len_ok     = (bus.pkt_len_i != '0) && (bus.pkt_len_i <= LEN_W'(MAX_PKT_FLITS));
  assign first_word = (remaining_q == len_q);
  assign last_word  = (remaining_q == LEN_W'(1));

  // Only VCs that are both free and currently accepting traffic may be locked.
  injector_vc_select #(
    .N (VC_NUM),
    .W (VC_SIZE)
  ) u_vc_select (
    .req   (bus.is_allocatable_i & bus.is_on_off_i),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .found (found)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pkt_hs && len_ok)    state_d = VC_SEL;
      VC_SEL:  if (found)               state_d = SEND;
      SEND:    if (pld_hs && last_word) state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    head_d.x_dest     = dest_x_q;
    head_d.y_dest     = dest_y_q;
    head_d.head_pl    = bus.pld_data_i[HEAD_PAYLOAD_SIZE-1:0];
    flit_d.flit_label = pick_label(len_q == LEN_W'(1), first_word, last_word);
    flit_d.vc_id      = vc_q;
    flit_d.data       = first_word ? head_d : bus.pld_data_i;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      vc_q        <= '0;
      dest_x_q    <= '0;
      dest_y_q    <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sent_q      <= 1'b0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      valid_q <= pld_hs;
      sent_q  <= pld_hs && last_word;
      error_q <= pkt_hs && !len_ok;

      if (pkt_hs && len_ok) begin
        dest_x_q    <= bus.pkt_dest_x_i;
        dest_y_q    <= bus.pkt_dest_y_i;
        len_q       <= bus.pkt_len_i;
        remaining_q <= bus.pkt_len_i;
      end

      // The VC is locked here; later allocatable changes do not affect this packet.
      if (state_q == VC_SEL && found) begin
        vc_q     <= grant;
        rr_ptr_q <= (grant == VC_SIZE'(VC_NUM - 1)) ? '0 : grant + VC_SIZE'(1);
      end

      // data_q only moves on a handshake, so it holds the last flit during stalls.
      if (pld_hs) begin
        data_q      <= flit_d;
        remaining_q <= remaining_q - LEN_W'(1);
        cnt_q       <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_node_injector.sv
// Self-checking bench for node_injector: descriptor table plus hand-written stall,
// VC-wait and async-reset sequences, with a flit scoreboard checked by a monitor.
module tb_node_injector;
  import noc_params::*;

  localparam int MAX_PKT_FLITS = 8;
  localparam int LEN_W         = $clog2(MAX_PKT_FLITS + 1);
  localparam int CNT_W         = 32;

  typedef struct {
    flit_t flit;
    logic  sent;
  } sb_entry_t;

  typedef struct {
    bit                          pre_rst;
    logic [DEST_ADDR_SIZE_X-1:0] x;
    logic [DEST_ADDR_SIZE_Y-1:0] y;
    logic [LEN_W-1:0]            len;
    logic [FLIT_DATA_SIZE-1:0]   base;
    bit                          exp_err;
    int                          exp_vc;
    int                          exp_cnt;
  } vec_t;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  int        checks = 0;
  int        failures = 0;
  sb_entry_t sb[$];
  sb_entry_t mon_e;
  time       head_time = 0;
  bit        desc_acc_flag = 1'b0;
  vec_t      vecs[7];

  always #5 clk = ~clk;

  node_injector_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  node_injector #(
    .X_CURRENT     (0),
    .Y_CURRENT     (0),
    .MAX_PKT_FLITS (MAX_PKT_FLITS),
    .LEN_W         (LEN_W),
    .CNT_W         (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid flit must match the oldest expected flit.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.is_valid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_flit", bus.data_o, '0);
        end else begin
          mon_e = sb.pop_front();
          check("flit", bus.data_o, mon_e.flit);
          check("pkt_sent", bus.pkt_sent_o, mon_e.sent);
          if (mon_e.flit.flit_label == HEAD || mon_e.flit.flit_label == HEADTAIL)
            head_time = $time;
        end
      end else begin
        check("sent_without_flit", bus.pkt_sent_o, 1'b0);
      end
    end
  end

  task automatic push_expected(input logic [DEST_ADDR_SIZE_X-1:0] x,
                               input logic [DEST_ADDR_SIZE_Y-1:0] y,
                               input int len, input logic [FLIT_DATA_SIZE-1:0] base,
                               input int vc, input int n);
    for (int i = 0; i < n; i++) begin
      sb_entry_t                 e;
      logic [FLIT_DATA_SIZE-1:0] w;
      w = base + FLIT_DATA_SIZE'(i);
      if (len == 1)            e.flit.flit_label = HEADTAIL;
      else if (i == 0)         e.flit.flit_label = HEAD;
      else if (i == len - 1)   e.flit.flit_label = TAIL;
      else                     e.flit.flit_label = BODY;
      e.flit.vc_id = VC_SIZE'(vc);
      e.flit.data  = (i == 0) ? {x, y, w[HEAD_PAYLOAD_SIZE-1:0]} : w;
      e.sent       = (i == len - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drive_desc(input logic [DEST_ADDR_SIZE_X-1:0] x,
                            input logic [DEST_ADDR_SIZE_Y-1:0] y,
                            input logic [LEN_W-1:0] len, output time t_hs, output bit ok);
    ok   = 1'b0;
    t_hs = 0;
    @(negedge clk);
    bus.pkt_valid_i  = 1'b1;
    bus.pkt_dest_x_i = x;
    bus.pkt_dest_y_i = y;
    bus.pkt_len_i    = len;
    for (int n = 0; n < 50 && !ok; n++) begin
      #1;
      if (bus.pkt_ready_o) begin
        @(posedge clk);
        t_hs          = $time;
        ok            = 1'b1;
        desc_acc_flag = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1 bus.pkt_valid_i = 1'b0;
    check("desc_handshake", ok, 1'b1);
  endtask

  task automatic drive_payload(input logic [FLIT_DATA_SIZE-1:0] base, input int n);
    int w = 0;
    int budget = 0;
    while (w < n && budget < 200) begin
      @(negedge clk);
      bus.pld_valid_i = 1'b1;
      bus.pld_data_i  = base + FLIT_DATA_SIZE'(w);
      #1;
      if (bus.pld_ready_o) begin
        @(posedge clk);
        w++;
      end
      budget++;
    end
    #1 bus.pld_valid_i = 1'b0;
    check("payload_handshakes", w, n);
  endtask

  task automatic send_pkt(input logic [DEST_ADDR_SIZE_X-1:0] x,
                          input logic [DEST_ADDR_SIZE_Y-1:0] y,
                          input logic [LEN_W-1:0] len, input logic [FLIT_DATA_SIZE-1:0] base,
                          input int vc, input int n_words, output time t_hs);
    bit ok;
    push_expected(x, y, int'(len), base, vc, n_words);
    drive_desc(x, y, len, t_hs, ok);
    if (ok) drive_payload(base, n_words);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t_acc;
    bit  ok;

    //          pre_rst x     y     len   base       err   vc cnt
    vecs[0] = '{1'b0, 2'd1, 2'd2, 4'd1, 16'h00A5, 1'b0, 0, 1};
    vecs[1] = '{1'b1, 2'd0, 2'd1, 4'd3, 16'h0100, 1'b0, 0, 3};
    vecs[2] = '{1'b0, 2'd2, 2'd3, 4'd3, 16'h0200, 1'b0, 1, 6};
    vecs[3] = '{1'b0, 2'd3, 2'd0, 4'd3, 16'h0300, 1'b0, 2, 9};
    vecs[4] = '{1'b0, 2'd0, 2'd0, 4'd0, 16'h0000, 1'b1, 0, 9};
    vecs[5] = '{1'b0, 2'd0, 2'd0, 4'd9, 16'h0000, 1'b1, 0, 9};
    vecs[6] = '{1'b0, 2'd1, 2'd1, 4'd8, 16'h0400, 1'b0, 3, 17};

    bus.pkt_valid_i      = 1'b0;
    bus.pkt_dest_x_i     = '0;
    bus.pkt_dest_y_i     = '0;
    bus.pkt_len_i        = '0;
    bus.pld_valid_i      = 1'b0;
    bus.pld_data_i       = '0;
    bus.is_on_off_i      = '1;
    bus.is_allocatable_i = '1;

    #12;
    check("rst_pkt_ready", bus.pkt_ready_o, 1'b1);
    check("rst_pld_ready", bus.pld_ready_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_valid", bus.is_valid_o, 1'b0);
    check("rst_sent", bus.pkt_sent_o, 1'b0);
    check("rst_error", bus.error_o, 1'b0);
    check("rst_data", bus.data_o, '0);
    check("rst_cnt", bus.flit_cnt_o, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].pre_rst) apply_reset();
      if (vecs[i].exp_err) begin
        drive_desc(vecs[i].x, vecs[i].y, vecs[i].len, t_acc, ok);
        @(negedge clk);
        #1;
        check("error_pulse", bus.error_o, 1'b1);
        check("error_stays_idle", bus.busy_o, 1'b0);
        @(negedge clk);
        #1;
        check("error_one_cycle", bus.error_o, 1'b0);
      end else begin
        send_pkt(vecs[i].x, vecs[i].y, vecs[i].len, vecs[i].base, vecs[i].exp_vc,
                 int'(vecs[i].len), t_acc);
        settle();
        check("head_latency", head_time - t_acc, 64'd25);
      end
      check("flit_cnt", bus.flit_cnt_o, vecs[i].exp_cnt);
      check("sb_drained", sb.size(), 0);
    end

    // On/off drop on the locked VC for 4 cycles right after the head handshake.
    desc_acc_flag = 1'b0;
    fork
      send_pkt(2'd2, 2'd2, 4'd3, 16'h0500, 0, 3, t_acc);
      begin
        for (int n = 0; n < 100 && !desc_acc_flag; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge clk);
          bus.is_on_off_i[0] = 1'b0;
          #2;
          check("stall_pld_ready", bus.pld_ready_o, 1'b0);
          if (k > 0) check("stall_no_flit", bus.is_valid_o, 1'b0);
        end
        @(negedge clk);
        bus.is_on_off_i = '1;
        #2;
        check("stall_no_flit", bus.is_valid_o, 1'b0);
      end
    join
    settle();
    check("stall_flit_cnt", bus.flit_cnt_o, 20);
    check("stall_sb_drained", sb.size(), 0);

    // No VC allocatable for 5 cycles after accept, then only VC 1.
    bus.is_allocatable_i = '0;
    desc_acc_flag = 1'b0;
    fork
      send_pkt(2'd0, 2'd3, 4'd2, 16'h0600, 1, 2, t_acc);
      begin
        for (int n = 0; n < 100 && !desc_acc_flag; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          #2;
          check("vcsel_busy", bus.busy_o, 1'b1);
          check("vcsel_no_flit", bus.is_valid_o, 1'b0);
          check("vcsel_pld_ready", bus.pld_ready_o, 1'b0);
        end
        @(negedge clk);
        bus.is_allocatable_i = 4'b0010;
      end
    join
    bus.is_allocatable_i = '1;
    settle();
    check("vcsel_flit_cnt", bus.flit_cnt_o, 22);
    check("vcsel_sb_drained", sb.size(), 0);

    // Async reset after the head of a len=4 packet (lands on vc 2).
    send_pkt(2'd3, 2'd3, 4'd4, 16'h0700, 2, 1, t_acc);
    @(negedge clk);
    #1;
    check("pre_reset_cnt", bus.flit_cnt_o, 23);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", bus.is_valid_o, 1'b0);
    check("async_rst_data", bus.data_o, '0);
    check("async_rst_cnt", bus.flit_cnt_o, '0);
    check("async_rst_busy", bus.busy_o, 1'b0);
    check("async_rst_pkt_ready", bus.pkt_ready_o, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_pkt(2'd1, 2'd0, 4'd2, 16'h0800, 0, 2, t_acc);
    settle();
    check("post_rst_latency", head_time - t_acc, 64'd25);
    check("post_rst_flit_cnt", bus.flit_cnt_o, 2);
    check("final_sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/node_injector.md
Name: node_injector

Overview:
- Local-port traffic source for a mesh node, driving one router local input (flit_t stream plus per-VC on/off and allocatable feedback).
- Accepts packet descriptors (destination, length) and a payload word stream. Emits a HEAD/BODY/TAIL or HEADTAIL flit sequence on one virtual channel, chosen round-robin.
- Generalises the plain local link with parametrised packet length, VC selection, flow-control stalls, error flagging and a flit counter; mesh benches and traffic generators instantiate one per node.

Parameters:
- X_CURRENT, 0, column of the attached router (reporting/debug only).
- Y_CURRENT, 0, row of the attached router (reporting/debug only).
- MAX_PKT_FLITS, 8, maximum flits per packet; legal lengths are 1..MAX_PKT_FLITS.
- LEN_W, $clog2(MAX_PKT_FLITS+1), width of the length field.
- CNT_W, 32, width of the sent-flit counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pkt_valid_i  in  1  descriptor valid
- pkt_ready_o  out  1  descriptor accepted when valid&ready
- pkt_dest_x_i  in  DEST_ADDR_SIZE_X  destination column
- pkt_dest_y_i  in  DEST_ADDR_SIZE_Y  destination row
- pkt_len_i  in  LEN_W  packet length in flits
- pld_valid_i  in  1  payload word valid
- pld_ready_o  out  1  payload word consumed when valid&ready
- pld_data_i  in  FLIT_DATA_SIZE  payload word; head flit uses the low HEAD_PAYLOAD_SIZE bits
- data_o  out  flit_t  flit to router local port
- is_valid_o  out  1  data_o valid
- is_on_off_i  in  VC_NUM  per-VC permission to send
- is_allocatable_i  in  VC_NUM  per-VC free for a new packet
- busy_o  out  1  state != IDLE
- pkt_sent_o  out  1  one-cycle pulse, coincident with the tail/headtail flit on data_o
- error_o  out  1  one-cycle pulse on an illegal descriptor
- flit_cnt_o  out  CNT_W  total flits emitted since reset

Behaviour:
- Reset (rst high, asynchronous, active-high):
  - state=IDLE; rr_ptr=0; all outputs 0 except pkt_ready_o=1; data_o='0; flit_cnt_o=0.
  - Reset mid-packet truncates the packet; no tail is emitted.
- FSM states: IDLE, VC_SEL, SEND.
- IDLE:
  - pkt_ready_o=1.
  - On handshake with 1<=pkt_len_i<=MAX_PKT_FLITS, latch dest, length and remaining=len, then go to VC_SEL.
  - On handshake with pkt_len_i==0 or >MAX_PKT_FLITS, pulse error_o next cycle, discard the descriptor, stay in IDLE.
- VC_SEL:
  - pkt_ready_o=0; pld_ready_o=0.
  - Search VCs from rr_ptr upward, wrapping, for the first v with is_allocatable_i[v] & is_on_off_i[v].
  - If found, latch vc=v, set rr_ptr=(v+1) mod VC_NUM, go to SEND. Otherwise stay in VC_SEL.
- SEND:
  - pld_ready_o = is_on_off_i[vc] (combinational).
  - On payload handshake, register a flit; it appears on data_o with is_valid_o=1 in the next cycle.
  - vc_id is the locked vc.
  - Label: HEADTAIL if len==1; otherwise HEAD first, TAIL when remaining==1, BODY in between.
  - Head flit carries dest x/y plus head payload; body and tail flits carry the full payload word.
  - remaining decrements on each handshake. After the last handshake, go to IDLE; pkt_sent_o is asserted with the last flit.
- Cycles with no handshake: is_valid_o=0; data_o holds its last value.
- is_on_off_i[vc] low mid-packet: stall, no flit, no data loss.
- is_allocatable_i changes after lock: ignored.
- flit_cnt_o increments once per emitted flit and wraps at 2^CNT_W.
- Latency:
  - Descriptor accept (cycle t) -> VC_SEL (t+1) -> first payload handshake at earliest t+2 -> head flit on data_o at t+3.
  - Back-to-back packets therefore have at least 2 idle output cycles between them.
- Never more than one flit per cycle. Never a flit on a VC whose on_off was low in the handshake cycle.

Decomposition:
- Shared package (noc_params): flit_t, flit_label_t (HEAD/BODY/TAIL/HEADTAIL), VC_NUM, VC_SIZE, DEST_ADDR_SIZE_X/Y, HEAD_PAYLOAD_SIZE, FLIT_DATA_SIZE.
- Injector-local: enum injector_state_t {IDLE, VC_SEL, SEND}.
- One sub-module, injector_vc_select: combinational rotating priority search over VC_NUM request bits from rr_ptr. Outputs a grant index and a found flag.

Test Plan:
- Reset release with all VCs on/allocatable, descriptor dest=(1,2), len=1, payload 0xA5 -> one HEADTAIL flit on vc 0 at accept+3 with dest (1,2) and head payload 0xA5; pkt_sent_o pulse in the same cycle; flit_cnt_o=1.
- Three len=3 packets back-to-back, all VCs free -> VCs 0,1,2 used in order (rr rotates); labels HEAD,BODY,TAIL each time; flit_cnt_o=9.
- Mid-packet: drop is_on_off_i[vc] for 4 cycles after the HEAD -> pld_ready_o=0 and is_valid_o=0 for those 4 cycles; BODY/TAIL then resume with the payload order preserved.
- is_allocatable_i=0 on all VCs for 5 cycles after accept -> stays in VC_SEL with busy_o=1 and no flit; raise only VC 1 -> packet sent on vc 1.
- Descriptor len=0, then len=MAX_PKT_FLITS+1 -> error_o pulses twice, no flits, state returns to IDLE; a following len=MAX_PKT_FLITS packet sends 8 flits correctly.
- Assert rst asynchronously after the HEAD of a len=4 packet -> outputs cleared in the same cycle; after release, a new packet starts on vc 0 with a HEAD flit.
